// File: rtl/a2d_arb.sv
// Two-port arbiter for the shared A2D converter: port 0 has priority, port 1 is
// forced after STARVE_LIM back-to-back port-0 wins; conversions are watchdog-timed.
module a2d_arb #(
  parameter int TMO_W      = 13,
  parameter int TMO_CYC    = 5000,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [2:0]  chnnl0,
  input  logic        req1,
  input  logic [2:0]  chnnl1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res
);

  typedef enum logic [1:0] {IDLE, START, CONV, GAP} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [2:0]       LIM      = 3'(STARVE_LIM);

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [2:0]        starve_q, starve_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic              strt_q, strt_d;
  logic [2:0]        chnnl_q, chnnl_d;
  logic [11:0]       res_q, res_d;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    starve_d = starve_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    strt_d   = 1'b0;
    chnnl_d  = chnnl_q;
    res_d    = res_q;
    unique case (state_q)
      IDLE: begin
        // Port 0 wins unless port 1 has already been passed over LIM times in a row.
        if (req0 && (!req1 || starve_q < LIM)) begin
          gnt0_d   = 1'b1;
          chnnl_d  = chnnl0;
          starve_d = req1 ? starve_q + 3'd1 : 3'd0;
          strt_d   = 1'b1;
          state_d  = START;
        end else if (req1) begin
          gnt1_d   = 1'b1;
          chnnl_d  = chnnl1;
          starve_d = 3'd0;
          strt_d   = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        tmo_d = tmo_q + 1'b1;
        // The grant flops double as the owner record; completion beats timeout.
        if (cnv_cmplt) begin
          res_d   = A2D_res;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          state_d = GAP;
        end else if (tmo_q == TMO_LAST) begin
          err0_d  = gnt0_q;
          err1_d  = gnt1_q;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      starve_q <= 3'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      strt_q   <= 1'b0;
      chnnl_q  <= 3'd0;
      res_q    <= 12'h000;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      starve_q <= starve_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      strt_q   <= strt_d;
      chnnl_q  <= chnnl_d;
      res_q    <= res_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign strt_cnv = strt_q;
  assign chnnl    = chnnl_q;
  assign res      = res_q;

endmodule
